wb_port_arbiter: RTL and testbench

Arbitrates the single register-file write port between the pipeline writeback path (Stage5 output) and result returns from the DSP peripherals. Pipeline writes have absolute priority and are never delayed. DSP results enter through a valid/ready handshake into a small FIFO and drain into idle write slots. A starvation counter requests a pipeline stall so DSP results cannot be blocked indefinitely. The block sits between Stage5 and the register file write port.

---
 rtl/wb_port_arbiter.sv | 117 +++++++++++
 tb/tb_wb_port_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback always wins the port,
// DSP results queue in a small FIFO and drain into idle slots. A starvation
// counter raises stall_req so queued DSP results cannot wait forever.
module wb_port_arbiter #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8,
  localparam int unsigned LW          = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          Reg_Write_En_in,
  input  logic [4:0]    Addr_Write_Reg_in,
  input  logic [31:0]   Reg_Write_Data_in,
  input  logic          dsp_valid,
  output logic          dsp_ready,
  input  logic [4:0]    dsp_addr,
  input  logic [31:0]   dsp_data,
  output logic          Reg_Write_En_out,
  output logic [4:0]    Addr_Write_Reg_out,
  output logic [31:0]   Reg_Write_Data_out,
  output logic          stall_req,
  output logic [LW-1:0] dsp_level
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [LW-1:0] FullLevel  = LW'(DEPTH);
  localparam logic [SW-1:0] StarveMax  = SW'(STARVE_LIMIT);

  logic [4:0]    fifo_addr [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          stall_d;

  logic slot_taken, fifo_empty, push, pop;

  // Slot arbitration and FIFO handshake qualifiers.
  always_comb begin
    slot_taken = Reg_Write_En_in && (Addr_Write_Reg_in != 5'd0);
    fifo_empty = (level_q == '0);
    dsp_ready  = !reset && (level_q < FullLevel);
    // A zero-address result completes its handshake but is never stored.
    push       = dsp_valid && dsp_ready && (dsp_addr != 5'd0);
    pop        = !slot_taken && !fifo_empty;
  end

  // Next-state for FIFO occupancy, starvation counter and stall request.
  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (pop && !push) begin
      level_d = level_q - 1'b1;
    end

    starve_d = starve_q;
    if (pop || fifo_empty) begin
      starve_d = '0;
    end else if (slot_taken && (starve_q < StarveMax)) begin
      starve_d = starve_q + 1'b1;
    end

    // A pipeline write during a stall still wins, so only a pop releases it.
    stall_d = pop ? 1'b0 : (stall_req || (starve_d == StarveMax));
  end

  // FIFO storage; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr_q] <= dsp_addr;
      fifo_data[wr_ptr_q] <= dsp_data;
    end
  end

  // Pointer, level, starvation and stall state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      starve_q  <= '0;
      stall_req <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q   <= level_d;
      starve_q  <= starve_d;
      stall_req <= stall_d;
    end
  end

  // Registered write port: pipeline, then FIFO head, else idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Reg_Write_En_out   <= 1'b0;
      Addr_Write_Reg_out <= 5'd0;
      Reg_Write_Data_out <= 32'd0;
    end else if (slot_taken) begin
      Reg_Write_En_out   <= 1'b1;
      Addr_Write_Reg_out <= Addr_Write_Reg_in;
      Reg_Write_Data_out <= Reg_Write_Data_in;
    end else if (pop) begin
      Reg_Write_En_out   <= 1'b1;
      Addr_Write_Reg_out <= fifo_addr[rd_ptr_q];
      Reg_Write_Data_out <= fifo_data[rd_ptr_q];
    end else begin
      Reg_Write_En_out   <= 1'b0;
      Addr_Write_Reg_out <= 5'd0;
      Reg_Write_Data_out <= 32'd0;
    end
  end

  assign dsp_level = level_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter. Stimulus pushes each expected register
// write into a queue; a negedge monitor pops and compares every emitted write.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en_in = 1'b0;
  logic [4:0]  addr_in = 5'd0;
  logic [31:0] data_in = 32'd0;
  logic        dsp_valid = 1'b0;
  logic        dsp_ready;
  logic [4:0]  dsp_addr = 5'd0;
  logic [31:0] dsp_data = 32'd0;
  logic        en_out;
  logic [4:0]  addr_out;
  logic [31:0] data_out;
  logic        stall_req;
  logic [2:0]  dsp_level;

  int unsigned total = 0;
  int unsigned passed = 0;
  logic [36:0] exp_q [$];

  wb_port_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk                (clk),
    .reset              (reset),
    .Reg_Write_En_in    (en_in),
    .Addr_Write_Reg_in  (addr_in),
    .Reg_Write_Data_in  (data_in),
    .dsp_valid          (dsp_valid),
    .dsp_ready          (dsp_ready),
    .dsp_addr           (dsp_addr),
    .dsp_data           (dsp_data),
    .Reg_Write_En_out   (en_out),
    .Addr_Write_Reg_out (addr_out),
    .Reg_Write_Data_out (data_out),
    .stall_req          (stall_req),
    .dsp_level          (dsp_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [36:0] act, input logic [36:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic expect_write(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  // Monitor: every write presented on the port must be the next expected one.
  always @(negedge clk) begin
    if (!reset && en_out) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {addr_out, data_out}, 37'h0);
      end else begin
        check("write_order", {addr_out, data_out}, exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc_iter;
    int stall_iter;
    int idx;
    logic acc;

    // Reset with random inputs.
    en_in = 1'b1; addr_in = 5'($urandom); data_in = $urandom;
    dsp_valid = 1'b1; dsp_addr = 5'($urandom); dsp_data = $urandom;
    #15;
    check("rst_en_out", en_out, 0);
    check("rst_addr_out", addr_out, 0);
    check("rst_data_out", data_out, 0);
    check("rst_stall", stall_req, 0);
    check("rst_level", dsp_level, 0);
    check("rst_ready", dsp_ready, 0);
    #5;
    en_in = 0; addr_in = 0; data_in = 0; dsp_valid = 0; dsp_addr = 0; dsp_data = 0;
    #2 reset = 1'b0;
    #1;
    check("post_rst_ready", dsp_ready, 1);
    check("post_rst_level", dsp_level, 0);
    step();

    // Pipeline only, then a discarded zero-address write.
    en_in = 1; addr_in = 5'd1; data_in = 32'd5;
    expect_write(5'd1, 32'd5);
    step();
    check("pipe_en_out", en_out, 1);
    addr_in = 5'd0; data_in = 32'h77;
    step();
    check("pipe_zero_en_out", en_out, 0);
    en_in = 0;

    // DSP only with the pipeline idle.
    dsp_valid = 1; dsp_addr = 5'd3; dsp_data = 32'hA5;
    expect_write(5'd3, 32'hA5);
    step();
    dsp_valid = 0;
    check("dsp_level_after_accept", dsp_level, 1);
    check("dsp_no_bypass", en_out, 0);
    step();
    check("dsp_en_out", en_out, 1);
    check("dsp_level_after_pop", dsp_level, 0);

    // Zero-address DSP result: handshake completes, nothing stored.
    dsp_valid = 1; dsp_addr = 5'd0; dsp_data = 32'hDEAD;
    check("zero_ready", dsp_ready, 1);
    step();
    dsp_valid = 0;
    check("zero_level", dsp_level, 0);
    repeat (3) step();

    // Fill and starve: pipeline busy every cycle, DSP offers addr 4..8.
    idx = 0;
    stall_iter = -1;
    for (int cyc = 0; cyc < 20 && stall_iter < 0; cyc++) begin
      en_in = 1; addr_in = 5'd2; data_in = 32'h100 + cyc;
      expect_write(5'd2, 32'h100 + cyc);
      dsp_valid = 1; dsp_addr = 5'(4 + idx); dsp_data = 32'hD0 + 4 + idx;
      acc = dsp_ready;
      step();
      if (acc) idx++;
      if (stall_req) stall_iter = cyc;
    end
    check("fill_accepted", idx, 4);
    check("fill_ready_low", dsp_ready, 0);
    check("fill_level", dsp_level, 4);
    check("stall_timing", stall_iter, 8);

    // Drain: pipeline drops, results leave in order, 5th enters when ready returns.
    en_in = 0; addr_in = 0; data_in = 0;
    for (int k = 4; k <= 8; k++) expect_write(5'(k), 32'hD0 + k);
    acc_iter = -1;
    for (int it = 0; it < 8; it++) begin
      acc = dsp_valid && dsp_ready;
      step();
      if (acc) begin
        acc_iter = it;
        dsp_valid = 0;
      end
      if (it == 0) check("stall_clear_on_pop", stall_req, 0);
      if (it < 5) check($sformatf("drain_consec_%0d", it), en_out, 1);
    end
    check("fifth_accept_iter", acc_iter, 1);
    check("drain_level", dsp_level, 0);

    // Reset mid-drain: three queued entries are flushed.
    for (int k = 0; k < 3; k++) begin
      en_in = 1; addr_in = 5'd9; data_in = 32'h200 + k;
      expect_write(5'd9, 32'h200 + k);
      dsp_valid = 1; dsp_addr = 5'(20 + k); dsp_data = 32'h300 + k;
      step();
    end
    dsp_valid = 0;
    check("pre_reset_level", dsp_level, 3);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_en_out", en_out, 0);
    check("mid_rst_level", dsp_level, 0);
    check("mid_rst_ready", dsp_ready, 0);
    en_in = 0; addr_in = 0; data_in = 0;
    step();
    reset = 1'b0;
    repeat (6) step();
    check("post_flush_level", dsp_level, 0);
    check("post_flush_ready", dsp_ready, 1);
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
